// File: rtl/object_scheduler.sv
// Falling-object game scheduler: waits a number of frames, spawns an object at
// a pseudo-random column, drops it a few lines per frame, and tracks catches
// (score) and misses until the game ends.
module object_scheduler #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned OBJ_SIZE    = 16,
  parameter int unsigned SPEED       = 2,
  parameter int unsigned SPAWN_DELAY = 30,
  parameter int unsigned MAX_MISS    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic        frame_tick,
  input  logic        hit,
  input  logic [31:0] random_number,
  output logic        lfsr_enable,
  output logic [10:0] obj_x,
  output logic [10:0] obj_y,
  output logic        obj_active,
  output logic [7:0]  score,
  output logic [3:0]  miss_count,
  output logic        game_over
);

  localparam int unsigned X_LIMIT = H_ACTIVE - OBJ_SIZE;
  localparam int unsigned Y_LIMIT = V_ACTIVE - OBJ_SIZE;
  localparam int unsigned CNT_W   = $clog2(SPAWN_DELAY + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT      = 3'd1,
    S_SPAWN     = 3'd2,
    S_FALL      = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   frame_cnt, frame_cnt_n;
  logic [10:0]        obj_x_n, obj_y_n;
  logic               obj_active_n;
  logic [7:0]         score_n;
  logic [3:0]         miss_count_n;
  logic               lfsr_enable_n;
  logic               game_over_n;

  // Derived arithmetic used by the next-state logic
  logic [9:0]         rnd;
  logic [CNT_W-1:0]   cnt_inc;
  logic [11:0]        y_sum;
  logic [3:0]         miss_inc;
  logic [7:0]         score_inc;
  logic [10:0]        spawn_x;
  logic               unused_rnd_bits;

  assign rnd             = random_number[9:0];
  assign unused_rnd_bits = ^random_number[31:10];
  assign cnt_inc         = frame_cnt + CNT_W'(1);
  assign y_sum           = {1'b0, obj_y} + 12'(SPEED);
  assign miss_inc        = miss_count + 4'd1;
  assign score_inc       = (score == 8'hFF) ? score : score + 8'd1;
  assign spawn_x         = ({1'b0, rnd} < 11'(X_LIMIT)) ? {1'b0, rnd}
                                                        : {1'b0, rnd} - 11'(X_LIMIT);

  // Next-state and next-output logic; pause freezes everything
  always_comb begin
    state_n      = state;
    frame_cnt_n  = frame_cnt;
    obj_x_n      = obj_x;
    obj_y_n      = obj_y;
    obj_active_n = obj_active;
    score_n      = score;
    miss_count_n = miss_count;

    if (!pause) begin
      case (state)
        S_IDLE: begin
          obj_active_n = 1'b0;
          if (start) begin
            state_n     = S_WAIT;
            frame_cnt_n = '0;
          end
        end
        S_WAIT: begin
          if (frame_tick) begin
            frame_cnt_n = cnt_inc;
            if (cnt_inc == CNT_W'(SPAWN_DELAY)) state_n = S_SPAWN;
          end
        end
        S_SPAWN: begin
          obj_x_n      = spawn_x;
          obj_y_n      = '0;
          obj_active_n = 1'b1;
          state_n      = S_FALL;
        end
        S_FALL: begin
          // A catch takes priority over a simultaneous bottom crossing
          if (hit) begin
            score_n      = score_inc;
            obj_active_n = 1'b0;
            frame_cnt_n  = '0;
            state_n      = S_WAIT;
          end else if (frame_tick) begin
            if (y_sum <= 12'(Y_LIMIT)) begin
              obj_y_n = y_sum[10:0];
            end else begin
              miss_count_n = miss_inc;
              obj_active_n = 1'b0;
              frame_cnt_n  = '0;
              state_n      = (miss_inc == 4'(MAX_MISS)) ? S_GAME_OVER : S_WAIT;
            end
          end
        end
        S_GAME_OVER: begin
          obj_active_n = 1'b0;
          if (start) begin
            score_n      = '0;
            miss_count_n = '0;
            frame_cnt_n  = '0;
            state_n      = S_WAIT;
          end
        end
        default: begin
          obj_active_n = 1'b0;
          state_n      = S_IDLE;
        end
      endcase
    end

    lfsr_enable_n = !pause && (state_n == S_WAIT);
    game_over_n   = (state_n == S_GAME_OVER);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      frame_cnt   <= '0;
      obj_x       <= '0;
      obj_y       <= '0;
      obj_active  <= 1'b0;
      score       <= '0;
      miss_count  <= '0;
      lfsr_enable <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_n;
      frame_cnt   <= frame_cnt_n;
      obj_x       <= obj_x_n;
      obj_y       <= obj_y_n;
      obj_active  <= obj_active_n;
      score       <= score_n;
      miss_count  <= miss_count_n;
      lfsr_enable <= lfsr_enable_n;
      game_over   <= game_over_n;
    end
  end

endmodule

// File: tb/tb_object_scheduler.sv
// Directed bench for object_scheduler with default parameters.
module tb_object_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        pause;
  logic        frame_tick;
  logic        hit;
  logic [31:0] random_number;
  logic        lfsr_enable;
  logic [10:0] obj_x;
  logic [10:0] obj_y;
  logic        obj_active;
  logic [7:0]  score;
  logic [3:0]  miss_count;
  logic        game_over;

  int checks = 0;
  int errors = 0;

  object_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pause         (pause),
    .frame_tick    (frame_tick),
    .hit           (hit),
    .random_number (random_number),
    .lfsr_enable   (lfsr_enable),
    .obj_x         (obj_x),
    .obj_y         (obj_y),
    .obj_active    (obj_active),
    .score         (score),
    .miss_count    (miss_count),
    .game_over     (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: inputs held across the edge, sampled 1 time unit after it
  task automatic step(input logic ft, input logic h);
    frame_tick = ft;
    hit        = h;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    hit        = 1'b0;
  endtask

  // From WAIT with a cleared counter: 30 ticks, then the SPAWN cycle
  task automatic spawn_obj(input logic [31:0] r);
    random_number = r;
    repeat (30) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; pause = 1'b0;
    frame_tick = 1'b0; hit = 1'b0; random_number = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_obj_active", 32'(obj_active), 32'd0);
    check("rst_lfsr", 32'(lfsr_enable), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_miss", 32'(miss_count), 32'd0);
    check("rst_game_over", 32'(game_over), 32'd0);
    check("rst_obj_xy", 32'({obj_x, obj_y}), 32'd0);
    rst = 1'b1;

    // Stays idle without start
    repeat (3) step(1'b1, 1'b0);
    check("idle_lfsr", 32'(lfsr_enable), 32'd0);

    // Start for one cycle -> WAIT
    start = 1'b1; step(1'b0, 1'b0); start = 1'b0;
    check("wait_lfsr", 32'(lfsr_enable), 32'd1);

    // 29 ticks stay in WAIT, 30th moves to SPAWN
    random_number = 32'hABCD_E000 | 32'd700;
    repeat (29) step(1'b1, 1'b0);
    check("wait29_lfsr", 32'(lfsr_enable), 32'd1);
    step(1'b1, 1'b0);
    check("spawn_lfsr", 32'(lfsr_enable), 32'd0);
    check("spawn_not_active", 32'(obj_active), 32'd0);
    step(1'b0, 1'b0);
    check("fall_active", 32'(obj_active), 32'd1);
    check("fall_y0", 32'(obj_y), 32'd0);
    check("spawn_x_700", 32'(obj_x), 32'd76);

    // Fall to the bottom, then miss
    step(1'b1, 1'b0);
    check("fall_y2", 32'(obj_y), 32'd2);
    repeat (231) step(1'b1, 1'b0);
    check("fall_y464", 32'(obj_y), 32'd464);
    check("fall_still_active", 32'(obj_active), 32'd1);
    step(1'b1, 1'b0);
    check("miss1_count", 32'(miss_count), 32'd1);
    check("miss1_inactive", 32'(obj_active), 32'd0);
    check("miss1_wait", 32'(lfsr_enable), 32'd1);

    // Second object: boundary column, hit together with the bottom crossing
    spawn_obj(32'd623);
    check("spawn_x_623", 32'(obj_x), 32'd623);
    repeat (232) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("hitmiss_score", 32'(score), 32'd1);
    check("hitmiss_miss", 32'(miss_count), 32'd1);
    check("hitmiss_inactive", 32'(obj_active), 32'd0);
    check("hitmiss_wait", 32'(lfsr_enable), 32'd1);

    // Hit outside FALL is ignored
    step(1'b0, 1'b1);
    check("hit_in_wait", 32'(score), 32'd1);

    // Pause in WAIT: lfsr off, frame ticks ignored
    pause = 1'b1;
    repeat (5) step(1'b1, 1'b0);
    check("pause_wait_lfsr", 32'(lfsr_enable), 32'd0);
    pause = 1'b0;
    step(1'b0, 1'b0);
    check("unpause_lfsr", 32'(lfsr_enable), 32'd1);
    random_number = 32'd5;
    repeat (29) step(1'b1, 1'b0);
    check("pause_cnt_frozen", 32'(lfsr_enable), 32'd1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("spawn_x_5", 32'(obj_x), 32'd5);

    // Pause mid-FALL
    repeat (10) step(1'b1, 1'b0);
    check("pre_pause_y", 32'(obj_y), 32'd20);
    pause = 1'b1;
    repeat (5) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    start = 1'b1; step(1'b1, 1'b0); start = 1'b0;
    check("pause_y", 32'(obj_y), 32'd20);
    check("pause_score", 32'(score), 32'd1);
    check("pause_active", 32'(obj_active), 32'd1);
    check("pause_fall_lfsr", 32'(lfsr_enable), 32'd0);
    pause = 1'b0;
    step(1'b1, 1'b0);
    check("resume_y", 32'(obj_y), 32'd22);
    repeat (221) step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("miss2_count", 32'(miss_count), 32'd2);

    // Third miss ends the game
    spawn_obj(32'd100);
    repeat (233) step(1'b1, 1'b0);
    check("go_flag", 32'(game_over), 32'd1);
    check("go_miss", 32'(miss_count), 32'd3);
    check("go_inactive", 32'(obj_active), 32'd0);
    check("go_lfsr", 32'(lfsr_enable), 32'd0);
    step(1'b1, 1'b1);
    check("go_hold_y", 32'(obj_y), 32'd464);
    check("go_hold_x", 32'(obj_x), 32'd100);
    check("go_hold_score", 32'(score), 32'd1);
    check("go_hold_flag", 32'(game_over), 32'd1);

    // Restart clears score and misses
    start = 1'b1; step(1'b0, 1'b0); start = 1'b0;
    check("restart_flag", 32'(game_over), 32'd0);
    check("restart_score", 32'(score), 32'd0);
    check("restart_miss", 32'(miss_count), 32'd0);
    check("restart_wait", 32'(lfsr_enable), 32'd1);

    // Score saturates at 255
    for (int i = 0; i < 256; i++) begin
      spawn_obj(32'(i));
      step(1'b0, 1'b1);
      if (i == 0) check("catch_first", 32'(score), 32'd1);
    end
    check("score_sat", 32'(score), 32'd255);
    check("score_sat_miss", 32'(miss_count), 32'd0);

    // Asynchronous reset mid-FALL
    spawn_obj(32'd1000);
    check("spawn_x_1000", 32'(obj_x), 32'd376);
    repeat (5) step(1'b1, 1'b0);
    check("pre_rst_y", 32'(obj_y), 32'd10);
    #2 rst = 1'b0;
    #1;
    check("arst_active", 32'(obj_active), 32'd0);
    check("arst_xy", 32'({obj_x, obj_y}), 32'd0);
    check("arst_score", 32'(score), 32'd0);
    check("arst_miss", 32'(miss_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) step(1'b1, 1'b1);
    check("post_rst_idle_lfsr", 32'(lfsr_enable), 32'd0);
    check("post_rst_idle_active", 32'(obj_active), 32'd0);
    start = 1'b1; step(1'b0, 1'b0); start = 1'b0;
    check("post_rst_start", 32'(lfsr_enable), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/object_scheduler.md
OBJECT_SCHEDULER -- requirements
Module: object_scheduler

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 SHALL have parameter OBJ_SIZE, default 16, object edge length in pixels.
REQ-004 SHALL have parameter SPEED, default 2, lines advanced per frame tick.
REQ-005 SHALL have parameter SPAWN_DELAY, default 30, frame ticks between object lifetimes.
REQ-006 SHALL have parameter MAX_MISS, default 3, misses that end the game.
REQ-007 SHALL have port clk  input  1  system clock; one clock only.
REQ-008 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-009 SHALL have port start  input  1  level; leaves IDLE or GAME_OVER.
REQ-010 SHALL have port pause  input  1  level; freezes all state while high.
REQ-011 SHALL have port frame_tick  input  1  one-cycle pulse per frame.
REQ-012 SHALL have port hit  input  1  one-cycle pulse; player caught the object.
REQ-013 SHALL have port random_number  input  32  LFSR value.
REQ-014 SHALL have port lfsr_enable  output  1  advance request to the LFSR.
REQ-015 SHALL have port obj_x  output  11  object left edge.
REQ-016 SHALL have port obj_y  output  11  object top edge.
REQ-017 SHALL have port obj_active  output  1  object drawn when high.
REQ-018 SHALL have port score  output  8  caught objects, saturating.
REQ-019 SHALL have port miss_count  output  4  missed objects.
REQ-020 SHALL have port game_over  output  1  high in GAME_OVER.

Function
REQ-021 SHALL implement states IDLE, WAIT, SPAWN, FALL, GAME_OVER; all outputs registered; transitions take effect on the next rising clk edge.
REQ-022 SHALL, when pause=1, hold state, counters, and outputs, and ignore frame_tick, hit, start; lfsr_enable=0.
REQ-023 SHALL go IDLE->WAIT when start=1; the frame counter is cleared on entry to WAIT.
REQ-024 SHALL, in WAIT, increment the frame counter on each frame_tick; go to SPAWN on the tick that makes the count equal SPAWN_DELAY.
REQ-025 SHALL drive lfsr_enable=1 only in WAIT and 0 in every other state, so random_number is stable in SPAWN.
REQ-026 SHALL, in SPAWN (exactly one cycle), set obj_x = r if r < H_ACTIVE-OBJ_SIZE, else r-(H_ACTIVE-OBJ_SIZE), where r = random_number[9:0] (default: r>=624 -> r-624); obj_y=0; obj_active=1; go to FALL.
REQ-027 SHALL, in FALL on frame_tick, set obj_y=obj_y+SPEED if obj_y+SPEED <= V_ACTIVE-OBJ_SIZE (sum computed 12 bits wide).
REQ-028 SHALL otherwise treat it as a miss: miss_count+1, obj_active=0; go to GAME_OVER if the new miss_count equals MAX_MISS, else WAIT.
REQ-029 SHALL, on hit in FALL: score+1 saturating at 255, obj_active=0, go to WAIT; hit outside FALL is ignored.
REQ-030 SHALL, on hit and a miss-causing frame_tick in the same cycle, apply hit only.
REQ-031 SHALL, in GAME_OVER, hold obj_x, obj_y, score, miss_count; obj_active=0; on start go to WAIT with score=0, miss_count=0.
REQ-032 SHALL have no state that can hang; unused encodings go to IDLE.

Reset
REQ-033 SHALL, while rst=0, asynchronously force state=IDLE, obj_x=0, obj_y=0, obj_active=0, score=0, miss_count=0, game_over=0, lfsr_enable=0, frame counter=0.
REQ-034 SHALL, on reset asserted mid-FALL, drop obj_active in the same cycle; after release, stay in IDLE until start.

Verification
REQ-035 SHALL cover: reset release, start=1 for one cycle, 30 frame_ticks -> SPAWN one cycle after the 30th tick, then FALL with obj_active=1, obj_y=0.
REQ-036 SHALL cover: random_number[9:0]=700 in SPAWN -> obj_x=76; random_number[9:0]=623 -> obj_x=623.
REQ-037 SHALL cover: FALL with no hit -> obj_y steps 0,2,...,464; the next tick is a miss, miss_count=1, state WAIT.
REQ-038 SHALL cover: hit and a bottom-crossing frame_tick in the same cycle -> score+1, miss_count unchanged.
REQ-039 SHALL cover: three misses -> game_over=1; then start -> score=0, miss_count=0, WAIT.
REQ-040 SHALL cover: pause=1 over 5 frame_ticks mid-FALL -> obj_y unchanged, lfsr_enable=0; and rst=0 mid-FALL -> all outputs reset immediately.
